// File: rtl/exe_stage.sv
// exe_stage: ARM execute stage (Val2 shifter, ALU, branch target, NZCV register, EX/MEM register); `FORWARDING_EN muxes forwarded operands in
module exe_stage #(
  parameter int W = 32,
  parameter logic [3:0] SR_RST = 4'b0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic         wb_en_in,
  input  logic         mem_r_en_in,
  input  logic         mem_w_en_in,
  input  logic [3:0]   exe_cmd,
  input  logic         b,
  input  logic         s,
  input  logic [W-1:0] pc,
  input  logic [W-1:0] val_rn,
  input  logic [W-1:0] val_rm,
  input  logic [11:0]  shift_operand,
  input  logic         imm,
  input  logic [23:0]  signed_imm_24,
  input  logic [3:0]   dest,
  input  logic [3:0]   sr_in,
  input  logic [1:0]   sel_src1,
  input  logic [1:0]   sel_src2,
  input  logic [W-1:0] mem_fwd_val,
  input  logic [W-1:0] wb_fwd_val,
  output logic         branch_taken,
  output logic [W-1:0] branch_addr,
  output logic [3:0]   sr,
  output logic         wb_en_out,
  output logic         mem_r_en_out,
  output logic         mem_w_en_out,
  output logic [W-1:0] alu_res,
  output logic [W-1:0] st_val,
  output logic [3:0]   dest_out
);
  logic [W-1:0] op1, op2, imm_ext, asr_v, val2, opb, res;
  logic [2*W-1:0] imm_dbl, reg_dbl;
  logic [4:0] sh;
  logic [3:0] cmd, flags;
  logic [W:0] sum;
  logic mem, is_add, is_sub, cin, ovf;
`ifdef FORWARDING_EN
  assign op1 = sel_src1 == 2'b01 ? mem_fwd_val : sel_src1 == 2'b10 ? wb_fwd_val : val_rn;
  assign op2 = sel_src2 == 2'b01 ? mem_fwd_val : sel_src2 == 2'b10 ? wb_fwd_val : val_rm;
`else
  logic unused_fwd;
  assign unused_fwd = ^{sel_src1, sel_src2, mem_fwd_val, wb_fwd_val};
  assign op1 = val_rn;
  assign op2 = val_rm;
`endif
  assign mem = mem_r_en_in | mem_w_en_in;
  assign imm_ext = W'(shift_operand[7:0]);
  assign imm_dbl = {imm_ext, imm_ext} >> {shift_operand[11:8], 1'b0};
  assign sh = shift_operand[11:7];
  assign reg_dbl = {op2, op2} >> sh;
  assign asr_v = $signed(op2) >>> sh;
  assign val2 = mem ? W'(shift_operand) :
                imm ? imm_dbl[W-1:0] :
                shift_operand[6:5] == 2'b00 ? op2 << sh :
                shift_operand[6:5] == 2'b01 ? op2 >> sh :
                shift_operand[6:5] == 2'b10 ? asr_v : reg_dbl[W-1:0];
  assign cmd = mem ? 4'b0010 : exe_cmd;
  assign is_add = cmd == 4'b0010 || cmd == 4'b0011;
  assign is_sub = cmd == 4'b0100 || cmd == 4'b0101;
  assign cin = cmd == 4'b0010 ? 1'b0 : cmd == 4'b0100 ? 1'b1 : sr_in[1];
  assign opb = is_sub ? ~val2 : val2;
  assign sum = {1'b0, op1} + {1'b0, opb} + (W+1)'(cin);
  assign res = (is_add || is_sub) ? sum[W-1:0] :
               cmd == 4'b0001 ? val2 :
               cmd == 4'b1001 ? ~val2 :
               cmd == 4'b0110 ? op1 & val2 :
               cmd == 4'b0111 ? op1 | val2 :
               cmd == 4'b1000 ? op1 ^ val2 : '0;
  assign ovf = (op1[W-1] == opb[W-1]) && (res[W-1] != op1[W-1]);
  assign flags = {res[W-1], res == '0, (is_add || is_sub) ? sum[W] : sr_in[1], (is_add || is_sub) ? ovf : sr_in[0]};
  assign branch_taken = b;
  assign branch_addr = pc + ({{(W-24){signed_imm_24[23]}}, signed_imm_24} << 2);
  always_ff @(posedge clk) begin
    if (rst) begin
      {wb_en_out, mem_r_en_out, mem_w_en_out} <= '0;
      alu_res <= '0;
      st_val <= '0;
      dest_out <= '0;
      sr <= SR_RST;
    end else if (!freeze) begin
      {wb_en_out, mem_r_en_out, mem_w_en_out} <= {wb_en_in, mem_r_en_in, mem_w_en_in};
      alu_res <= res;
      st_val <= op2;
      dest_out <= dest;
      if (s) sr <= flags;
    end
  end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: scoreboard bench for exe_stage against an independent arithmetic model
module tb_exe_stage;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, freeze, wb_en_in, mem_r_en_in, mem_w_en_in, b, s, imm;
  logic [3:0] exe_cmd, dest, sr_in;
  logic [31:0] pc, val_rn, val_rm, mem_fwd_val, wb_fwd_val;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [1:0] sel_src1, sel_src2;
  logic branch_taken, wb_en_out, mem_r_en_out, mem_w_en_out;
  logic [31:0] branch_addr, alu_res, st_val;
  logic [3:0] sr, dest_out;
  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .exe_cmd(exe_cmd), .b(b), .s(s), .pc(pc), .val_rn(val_rn),
    .val_rm(val_rm), .shift_operand(shift_operand), .imm(imm), .signed_imm_24(signed_imm_24),
    .dest(dest), .sr_in(sr_in), .sel_src1(sel_src1), .sel_src2(sel_src2),
    .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .sr(sr), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .alu_res(alu_res), .st_val(st_val), .dest_out(dest_out)
  );
  int checks = 0, failures = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  typedef struct {
    logic [31:0] alu;
    logic [31:0] st;
    logic [3:0] dest;
    logic [3:0] sr;
    logic [2:0] ctl;
  } exp_t;
  exp_t q[$];
  exp_t m = '{default: '0};
  function automatic logic [31:0] m_val2(input logic mem, input logic im, input logic [11:0] so, input logic [31:0] rm);
    logic [31:0] r, asr;
    int n;
    if (mem) return {20'b0, so};
    if (im) begin
      r = {24'b0, so[7:0]};
      n = 2 * so[11:8];
      return n == 0 ? r : (r >> n) | (r << (32 - n));
    end
    n = so[11:7];
    asr = $signed(rm) >>> n;
    case (so[6:5])
      2'b00: return rm << n;
      2'b01: return rm >> n;
      2'b10: return asr;
      default: return n == 0 ? rm : (rm >> n) | (rm << (32 - n));
    endcase
  endfunction
  function automatic logic [35:0] m_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] bv, input logic [3:0] f);
    logic [31:0] r;
    logic [63:0] t;
    logic cf, vf;
    longint sa, sb, ls, k;
    longint unsigned ua, ub;
    cf = f[1];
    vf = f[0];
    sa = $signed(a);
    sb = $signed(bv);
    ua = a;
    ub = bv;
    case (c)
      4'd1: r = bv;
      4'd9: r = ~bv;
      4'd6: r = a & bv;
      4'd7: r = a | bv;
      4'd8: r = a ^ bv;
      4'd2, 4'd3: begin
        k = (c == 4'd3) ? longint'(f[1]) : 0;
        t = ua + ub + k;
        r = t[31:0];
        cf = t[32];
        ls = sa + sb + k;
        vf = ls > 64'sd2147483647 || ls < -64'sd2147483648;
      end
      4'd4, 4'd5: begin
        k = (c == 4'd4) ? 0 : longint'(!f[1]);
        r = a - bv - k[31:0];
        cf = ua >= ub + k;
        ls = sa - sb - k;
        vf = ls > 64'sd2147483647 || ls < -64'sd2147483648;
      end
      default: r = '0;
    endcase
    return {r[31], r == 0, cf, vf, r};
  endfunction
  task automatic drive(input logic [3:0] c, input logic s_i, input logic im, input logic [31:0] rn, input logic [31:0] rm, input logic [11:0] so);
    logic [31:0] o1, o2, v2, ba;
    logic [35:0] ar;
    logic mem;
    exp_t e;
    @(negedge clk);
    exe_cmd = c;
    s = s_i;
    imm = im;
    val_rn = rn;
    val_rm = rm;
    shift_operand = so;
    sr_in = m.sr;
    o1 = rn;
    o2 = rm;
`ifdef FORWARDING_EN
    if (sel_src1 == 2'd1) o1 = mem_fwd_val;
    else if (sel_src1 == 2'd2) o1 = wb_fwd_val;
    if (sel_src2 == 2'd1) o2 = mem_fwd_val;
    else if (sel_src2 == 2'd2) o2 = wb_fwd_val;
`endif
    mem = mem_r_en_in | mem_w_en_in;
    v2 = m_val2(mem, im, so, o2);
    ar = m_alu(mem ? 4'd2 : c, o1, v2, m.sr);
    if (rst) m = '{default: '0};
    else if (!freeze) begin
      m.alu = ar[31:0];
      m.st = o2;
      m.dest = dest;
      m.ctl = {wb_en_in, mem_r_en_in, mem_w_en_in};
      if (s_i) m.sr = ar[35:32];
    end
    q.push_back(m);
    #1;
    ba = pc + ($signed({{8{signed_imm_24[23]}}, signed_imm_24}) * 4);
    check("branch_taken", 32'(branch_taken), 32'(b));
    check("branch_addr", branch_addr, ba);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("alu_res", alu_res, e.alu);
    check("st_val", st_val, e.st);
    check("dest_out", 32'(dest_out), 32'(e.dest));
    check("ctl_out", 32'({wb_en_out, mem_r_en_out, mem_w_en_out}), 32'(e.ctl));
    check("sr", 32'(sr), 32'(e.sr));
  endtask
  logic [31:0] edges [5] = '{32'h0, 32'h1, 32'h7fffffff, 32'h80000000, 32'hffffffff};
  initial begin
    rst = 1; freeze = 0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; b = 0; s = 0; imm = 0;
    exe_cmd = 0; dest = 0; sr_in = 0; pc = 0; val_rn = 0; val_rm = 0; mem_fwd_val = 0; wb_fwd_val = 0;
    shift_operand = 0; signed_imm_24 = 0; sel_src1 = 0; sel_src2 = 0;
    drive(4'd0, 1'b0, 1'b0, 0, 0, 12'h0);
    drive(4'd2, 1'b1, 1'b1, 32'h5, 32'h9, 12'h0ff);
    check("rst_alu", alu_res, 32'h0);
    check("rst_sr", 32'(sr), 32'h0);
    rst = 0; wb_en_in = 1; dest = 4'd2;
    drive(4'b0010, 1'b1, 1'b1, 32'd5, 32'd0, 12'h00a);
    check("add_imm", alu_res, 32'd15);
    check("add_sr", 32'(sr), 32'h0);
    drive(4'b0100, 1'b1, 1'b1, 32'd3, 32'd0, 12'h005);
    check("sub_neg", alu_res, 32'hfffffffe);
    check("sub_sr", 32'(sr), 32'b1000);
    drive(4'b0001, 1'b0, 1'b1, 32'd0, 32'd0, 12'h4ff);
    check("mov_rot", alu_res, 32'hff000000);
    drive(4'b0001, 1'b0, 1'b0, 32'd0, 32'd1, 12'h200);
    check("mov_lsl4", alu_res, 32'h10);
    mem_r_en_in = 1; dest = 4'd3;
    drive(4'b0010, 1'b0, 1'b0, 32'h100, 32'h0, 12'hfff);
    check("ldr_addr", alu_res, 32'h10ff);
    check("ldr_ren", 32'(mem_r_en_out), 32'h1);
    check("ldr_sr_hold", 32'(sr), 32'b1000);
    mem_r_en_in = 0; b = 1; pc = 32'h20; signed_imm_24 = 24'hfffffe;
    drive(4'b0111, 1'b0, 1'b0, 32'h0f0, 32'h00f, 12'h0);
    check("b_taken", 32'(branch_taken), 32'h1);
    check("b_addr", branch_addr, 32'h18);
    b = 0; freeze = 1;
    drive(4'b0010, 1'b1, 1'b1, 32'h55, 32'h7, 12'h001);
    check("frz_alu", alu_res, 32'h0ff);
    check("frz_sr", 32'(sr), 32'b1000);
    rst = 1;
    drive(4'b0010, 1'b1, 1'b1, 32'h55, 32'h7, 12'h001);
    check("rst_frz", alu_res, 32'h0);
    rst = 0; freeze = 0; sel_src1 = 2'b01; mem_fwd_val = 32'd7;
    drive(4'b0010, 1'b0, 1'b1, 32'd100, 32'd0, 12'h001);
`ifdef FORWARDING_EN
    check("fwd_add", alu_res, 32'd8);
`else
    check("fwd_add", alu_res, 32'd101);
`endif
    for (int i = 0; i < 120; i++) begin
      rst = ($urandom % 40) == 0;
      freeze = ($urandom % 8) == 0;
      wb_en_in = 1'($urandom);
      mem_r_en_in = ($urandom % 4) == 0;
      mem_w_en_in = !mem_r_en_in && ($urandom % 6) == 0;
      dest = 4'($urandom);
      b = 1'($urandom);
      pc = $urandom;
      signed_imm_24 = 24'($urandom);
      sel_src1 = 2'($urandom);
      sel_src2 = 2'($urandom);
      mem_fwd_val = ($urandom % 3) == 0 ? edges[$urandom % 5] : $urandom;
      wb_fwd_val = $urandom;
      drive(4'($urandom), 1'($urandom), 1'($urandom),
            ($urandom % 3) == 0 ? edges[$urandom % 5] : $urandom,
            ($urandom % 3) == 0 ? edges[$urandom % 5] : $urandom,
            12'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
